// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, transmitter state encoding and frame length helper.
package uart_pkg;

    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    // Start bit + payload + stop bit.
    function automatic int frame_len(input int data_width);
        return data_width + 2;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO holding words waiting to be framed and sent.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH      = 9,
    parameter int FIFO_ADDR_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    input  logic                       pop_i,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [FIFO_ADDR_WIDTH:0]   count_o
);

    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam int CW    = FIFO_ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0]      mem_q [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q;
    logic [FIFO_ADDR_WIDTH:0]   count_q;
    logic                       do_push;
    logic                       do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Requests against a full/empty FIFO are dropped here so callers need not gate them.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_ADDR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_ADDR_WIDTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit front end: buffers words and shifts each out as start + LSB-first data + stop,
// paced by an external baud tick counter that it holds in reset while idle.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH      = 9,
    parameter int FIFO_DEPTH      = 8,
    parameter int FIFO_ADDR_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    transmit_data,
    input  logic                     transmit_valid,
    output logic                     transmit_ready,
    output logic [FIFO_ADDR_WIDTH:0] fifo_space,
    input  logic                     baud_clock_rising_edge,
    input  logic                     all_bits_transmitted,
    output logic                     reset_counters,
    output logic                     tx_busy,
    output logic                     serial_out
);

    localparam int FRAME = frame_len(DATA_WIDTH);
    localparam int CW    = FIFO_ADDR_WIDTH + 1;

    tx_state_t               state_q;
    logic [FRAME-1:0]        shift_q;
    logic                    reset_counters_q;
    logic                    tx_busy_q;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   fifo_rdata;
    logic [FIFO_ADDR_WIDTH:0] fifo_count;

    assign transmit_ready = !fifo_full && !reset;
    assign fifo_push      = transmit_valid && transmit_ready;
    assign fifo_pop       = (state_q == TX_IDLE) && !fifo_empty;
    assign fifo_space     = CW'(FIFO_DEPTH) - fifo_count;

    uart_tx_fifo #(
        .DATA_WIDTH      (DATA_WIDTH),
        .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (transmit_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The shift register doubles as the TX output flop; bit 0 is always on the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= TX_IDLE;
            shift_q          <= {FRAME{UART_IDLE_LEVEL}};
            reset_counters_q <= 1'b1;
            tx_busy_q        <= 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        state_q          <= TX_SHIFT;
                        shift_q          <= {UART_STOP_BIT, fifo_rdata, UART_START_BIT};
                        reset_counters_q <= 1'b0;
                        tx_busy_q        <= 1'b1;
                    end else begin
                        shift_q          <= {FRAME{UART_IDLE_LEVEL}};
                        reset_counters_q <= 1'b1;
                        tx_busy_q        <= 1'b0;
                    end
                end
                TX_SHIFT: begin
                    // End of frame takes priority over the final baud tick.
                    if (all_bits_transmitted) begin
                        state_q          <= TX_IDLE;
                        shift_q          <= {FRAME{UART_IDLE_LEVEL}};
                        reset_counters_q <= 1'b1;
                        tx_busy_q        <= 1'b0;
                    end else if (baud_clock_rising_edge) begin
                        shift_q <= {UART_IDLE_LEVEL, shift_q[FRAME-1:1]};
                    end
                end
                default: begin
                    state_q          <= TX_IDLE;
                    shift_q          <= {FRAME{UART_IDLE_LEVEL}};
                    reset_counters_q <= 1'b1;
                    tx_busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign reset_counters = reset_counters_q;
    assign tx_busy        = tx_busy_q;
    assign serial_out     = shift_q[0];

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: serializer paired with a small baud tick counter (BAUD_COUNT=5, 9-bit words).
module tb_uart_tx_serializer;

    localparam int DW    = 9;
    localparam int AW    = 3;
    localparam int BAUD  = 5;
    localparam int FRAME = DW + 2;

    logic          clk;
    logic          reset;
    logic [DW-1:0] transmit_data;
    logic          transmit_valid;
    logic          transmit_ready;
    logic [AW:0]   fifo_space;
    logic          baud_clock_rising_edge;
    logic          all_bits_transmitted;
    logic          reset_counters;
    logic          tx_busy;
    logic          serial_out;

    int errors = 0;
    int checks = 0;

    uart_tx_serializer #(
        .DATA_WIDTH      (DW),
        .FIFO_DEPTH      (8),
        .FIFO_ADDR_WIDTH (AW)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .transmit_data          (transmit_data),
        .transmit_valid         (transmit_valid),
        .transmit_ready         (transmit_ready),
        .fifo_space             (fifo_space),
        .baud_clock_rising_edge (baud_clock_rising_edge),
        .all_bits_transmitted   (all_bits_transmitted),
        .reset_counters         (reset_counters),
        .tx_busy                (tx_busy),
        .serial_out             (serial_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick counter: tick on the last cycle of each bit period; done coincides with the 11th tick.
    logic [2:0] bcnt;
    logic [3:0] bits;
    assign baud_clock_rising_edge = !reset_counters && (bcnt == 3'(BAUD - 1));
    assign all_bits_transmitted   = baud_clock_rising_edge && (bits == 4'(FRAME - 1));
    always_ff @(posedge clk) begin
        if (reset || reset_counters) begin
            bcnt <= '0;
            bits <= '0;
        end else if (baud_clock_rising_edge) begin
            bcnt <= '0;
            bits <= bits + 4'd1;
        end else begin
            bcnt <= bcnt + 3'd1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples each bit mid-period, records word, framing and start cycle.
    logic [FRAME-1:0] sh;
    int               pos;
    int               st;
    bit               active = 1'b0;
    logic [DW-1:0]    rx_q[$];
    int               rx_start[$];
    bit               rx_ok[$];
    always @(negedge clk) begin
        if (!active) begin
            if (tx_busy === 1'b1 && serial_out === 1'b0) begin
                active = 1'b1;
                pos    = 0;
                st     = cyc;
            end
        end else begin
            pos++;
            if (tx_busy !== 1'b1) begin
                active = 1'b0;
            end else begin
                if (pos % BAUD == 2) sh[pos / BAUD] = serial_out;
                if (pos == FRAME * BAUD - 1) begin
                    active = 1'b0;
                    rx_q.push_back(sh[DW:1]);
                    rx_start.push_back(st);
                    rx_ok.push_back(sh[0] == 1'b0 && sh[FRAME-1] == 1'b1);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rx(input int n, input string tag);
        int g = 0;
        while (rx_q.size() < n && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk(tag, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int g = 0;
        while (tx_busy !== lvl && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk(tag, 32'(tx_busy), 32'(lvl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [FRAME-1:0] f0a5;
    logic [DW-1:0]    burst [8];
    logic [DW-1:0]    pp [5];
    int               n0;
    bit               stay_hi;

    initial begin
        f0a5  = 11'h54A;
        burst = '{9'h101, 9'h0FE, 9'h055, 9'h1AA, 9'h003, 9'h180, 9'h07F, 9'h111};
        pp    = '{9'h0C3, 9'h013, 9'h124, 9'h0F0, 9'h16B};

        reset = 1'b1; transmit_valid = 1'b0; transmit_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(transmit_ready), 0);
        chk("rst_space", 32'(fifo_space), 8);
        chk("rst_rc", 32'(reset_counters), 1);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_serial", 32'(serial_out), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(transmit_ready), 1);

        // Single word 0x0A5: every cycle of the frame checked against hand-built line pattern.
        transmit_data = 9'h0A5; transmit_valid = 1'b1;
        @(negedge clk);
        transmit_valid = 1'b0;
        chk("w1_space", 32'(fifo_space), 7);
        chk("w1_serial_idle", 32'(serial_out), 1);
        chk("w1_rc_idle", 32'(reset_counters), 1);
        for (int i = 0; i < FRAME * BAUD; i++) begin
            @(negedge clk);
            chk($sformatf("w1_bit_cyc%0d", i), 32'(serial_out), 32'(f0a5[i / BAUD]));
            chk($sformatf("w1_rc_cyc%0d", i), 32'(reset_counters), 0);
            chk($sformatf("w1_busy_cyc%0d", i), 32'(tx_busy), 1);
        end
        @(negedge clk);
        chk("w1_end_busy", 32'(tx_busy), 0);
        chk("w1_end_rc", 32'(reset_counters), 1);
        chk("w1_end_serial", 32'(serial_out), 1);
        chk("w1_end_space", 32'(fifo_space), 8);
        wait_rx(1, "w1_rx_count");
        chk("w1_rx_word", 32'(rx_q[0]), 32'h0A5);
        chk("w1_rx_frame", 32'(rx_ok[0]), 1);

        // Burst of 8 behind an all-zeros frame, then overflow hold with 0x1FF.
        transmit_data = 9'h000; transmit_valid = 1'b1;
        @(negedge clk);
        transmit_valid = 1'b0;
        wait_busy(1'b1, "b_busy_rise");
        for (int i = 0; i < 8; i++) begin
            transmit_data = burst[i]; transmit_valid = 1'b1;
            @(negedge clk);
        end
        chk("b_full_ready", 32'(transmit_ready), 0);
        chk("b_full_space", 32'(fifo_space), 0);
        transmit_data = 9'h1FF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("ovf_ready_%0d", i), 32'(transmit_ready), 0);
            chk($sformatf("ovf_space_%0d", i), 32'(fifo_space), 0);
        end
        begin
            int g = 0;
            while (transmit_ready !== 1'b1 && g < 200) begin
                @(negedge clk);
                g++;
            end
        end
        chk("ovf_ready_return", 32'(transmit_ready), 1);
        chk("ovf_space_one", 32'(fifo_space), 1);
        @(negedge clk);
        transmit_valid = 1'b0;
        chk("ovf_accepted_space", 32'(fifo_space), 0);
        wait_rx(11, "b_rx_count");
        chk("b_rx_w0", 32'(rx_q[1]), 32'h000);
        chk("b_rx_w0_frame", 32'(rx_ok[1]), 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b_rx_%0d", i), 32'(rx_q[2 + i]), 32'(burst[i]));
            chk($sformatf("b_rx_frame_%0d", i), 32'(rx_ok[2 + i]), 1);
        end
        chk("ovf_rx_word", 32'(rx_q[10]), 32'h1FF);
        chk("ovf_rx_frame", 32'(rx_ok[10]), 1);
        for (int i = 1; i < 10; i++) begin
            chk($sformatf("b_gap_%0d", i), 32'(rx_start[i + 1] - rx_start[i]), 32'(FRAME * BAUD + 1));
        end
        chk("b_end_space", 32'(fifo_space), 8);

        // Push on the same edge as a pop with three words queued.
        transmit_data = pp[0]; transmit_valid = 1'b1;
        @(negedge clk);
        transmit_valid = 1'b0;
        wait_busy(1'b1, "pp_busy_rise");
        for (int i = 1; i < 4; i++) begin
            transmit_data = pp[i]; transmit_valid = 1'b1;
            @(negedge clk);
        end
        transmit_valid = 1'b0;
        chk("pp_space_before", 32'(fifo_space), 5);
        wait_busy(1'b0, "pp_idle_gap");
        chk("pp_space_gap", 32'(fifo_space), 5);
        transmit_data = pp[4]; transmit_valid = 1'b1;
        @(negedge clk);
        transmit_valid = 1'b0;
        chk("pp_space_after", 32'(fifo_space), 5);
        chk("pp_busy_after", 32'(tx_busy), 1);
        wait_rx(16, "pp_rx_count");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pp_rx_%0d", i), 32'(rx_q[11 + i]), 32'(pp[i]));
            chk($sformatf("pp_rx_frame_%0d", i), 32'(rx_ok[11 + i]), 1);
        end

        // Reset during data bit 4 of 0x0E3 with two more words queued.
        transmit_data = 9'h0E3; transmit_valid = 1'b1;
        @(negedge clk);
        transmit_valid = 1'b0;
        wait_busy(1'b1, "mr_busy_rise");
        transmit_data = 9'h0AA; transmit_valid = 1'b1;
        @(negedge clk);
        transmit_data = 9'h1C7;
        @(negedge clk);
        transmit_valid = 1'b0;
        repeat (25) @(negedge clk);
        chk("mr_bit4_low", 32'(serial_out), 0);
        n0 = rx_q.size();
        reset = 1'b1;
        @(negedge clk);
        chk("mr_serial", 32'(serial_out), 1);
        chk("mr_space", 32'(fifo_space), 8);
        chk("mr_ready", 32'(transmit_ready), 0);
        chk("mr_rc", 32'(reset_counters), 1);
        chk("mr_busy", 32'(tx_busy), 0);
        reset = 1'b0;
        stay_hi = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || tx_busy !== 1'b0) stay_hi = 1'b0;
        end
        chk("mr_line_quiet", 32'(stay_hi), 1);
        chk("mr_no_frames", 32'(rx_q.size()), 32'(n0));
        chk("mr_space_after", 32'(fifo_space), 8);
        chk("mr_ready_after", 32'(transmit_ready), 1);
        transmit_data = 9'h155; transmit_valid = 1'b1;
        @(negedge clk);
        transmit_valid = 1'b0;
        wait_rx(n0 + 1, "mr_rx_count");
        chk("mr_rx_word", 32'(rx_q[n0]), 32'h155);
        chk("mr_rx_frame", 32'(rx_ok[n0]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
